// File: rtl/ap1000_rst_pkg.sv
// Shared definitions for the ap1000 reset sequencer.
//   - rst_state_e : sequencer state encoding (3 bits)
//   - CNT_W       : width of the saturating retry / lock-loss counters
//   - tmr_width() : state-timer width that covers the largest cycle parameter
package ap1000_rst_pkg;

  typedef enum logic [2:0] {
    ST_DCM_RST   = 3'd0,
    ST_SW_HOLD   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } rst_state_e;

  localparam int CNT_W = 8;

  // The timer only ever needs to hold (param - 1), so clog2(max) bits suffice.
  function automatic int tmr_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ap1000_lock_sync.sv
// Lock-input synchroniser.
//   plb_clk    : clock
//   clr        : synchronous clear of both flop ranks
//   dcm_locked : raw, asynchronous DCM lock indicators
//   all_locked : AND of the synchronised lock bits (2 cycles of latency)
module ap1000_lock_sync #(
  parameter int NUM_LOCKS = 3
) (
  input  logic                 plb_clk,
  input  logic                 clr,
  input  logic [NUM_LOCKS-1:0] dcm_locked,
  output logic                 all_locked
);

  logic [NUM_LOCKS-1:0] meta;
  logic [NUM_LOCKS-1:0] sync;

  always_ff @(posedge plb_clk) begin
    if (clr) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= dcm_locked;
      sync <= meta;
    end
  end

  assign all_locked = &sync;

endmodule

// File: rtl/ap1000_reset_sequencer.sv
// Board reset sequencer: pulses the DCM reset, waits for a stable lock on all
// DCMs (with timeout-and-retry), then releases NUM_STAGES reset domains in
// order, STAGE_GAP cycles apart. Lock loss and a software request send the
// whole sequence back to the start.
//   plb_clk       : sole clock
//   RSTPLB        : synchronous active-high reset
//   dcm_locked    : asynchronous DCM lock indicators
//   sw_rst_req    : single-cycle software reset request
//   dcm_rst       : active-high DCM reset
//   rst_out       : sequenced active-high resets, bit 0 released first
//   seq_done      : high while every stage is released
//   retry_cnt     : saturating count of lock timeouts
//   lock_loss_cnt : saturating count of lock losses after release
module ap1000_reset_sequencer
  import ap1000_rst_pkg::*;
#(
  parameter int NUM_LOCKS      = 3,
  parameter int LOCK_STABLE    = 8,
  parameter int NUM_STAGES     = 3,
  parameter int STAGE_GAP      = 4,
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1023
) (
  input  logic                  plb_clk,
  input  logic                  RSTPLB,
  input  logic [NUM_LOCKS-1:0]  dcm_locked,
  input  logic                  sw_rst_req,
  output logic                  dcm_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic [CNT_W-1:0]      retry_cnt,
  output logic [CNT_W-1:0]      lock_loss_cnt
);

  localparam int TW = tmr_width(LOCK_STABLE, STAGE_GAP, DCM_RST_CYCLES, LOCK_TIMEOUT);

  localparam logic [TW-1:0]    HOLD_LAST = TW'(DCM_RST_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LAST  = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);

  rst_state_e            st;
  logic [TW-1:0]         tmr;
  logic [CNT_W-1:0]      stb_cnt;
  logic                  all_locked;
  logic [NUM_STAGES-1:0] rst_shl;
  logic                  sync_clr;

  // Releasing a stage shifts a zero in at the bottom, so bits can only ever
  // fall in order; the only way back up is the all-ones load.
  assign rst_shl = rst_out << 1;

  // A DCM held in reset reports meaningless lock, so the synchroniser is held
  // empty while dcm_rst is high and lock is only counted once it re-emerges.
  assign sync_clr = RSTPLB | dcm_rst;

  ap1000_lock_sync #(
    .NUM_LOCKS (NUM_LOCKS)
  ) u_lock_sync (
    .plb_clk    (plb_clk),
    .clr        (sync_clr),
    .dcm_locked (dcm_locked),
    .all_locked (all_locked)
  );

  always_ff @(posedge plb_clk) begin
    if (RSTPLB) begin
      st            <= ST_DCM_RST;
      dcm_rst       <= 1'b1;
      rst_out       <= '1;
      seq_done      <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      tmr           <= '0;
      stb_cnt       <= '0;
    end else begin
      tmr <= tmr + 1'b1;
      case (st)
        ST_DCM_RST, ST_SW_HOLD: begin
          if (tmr == HOLD_LAST) begin
            st      <= ST_WAIT_LOCK;
            dcm_rst <= 1'b0;
            tmr     <= '0;
            stb_cnt <= '0;
          end
        end

        ST_WAIT_LOCK: begin
          // Stability wins over a timeout landing on the same cycle.
          if (all_locked && stb_cnt == STB_LAST) begin
            rst_out <= rst_shl;
            tmr     <= '0;
            if (rst_shl == '0) begin
              st       <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              st <= ST_RELEASE;
            end
          end else if (tmr == TO_LAST) begin
            st      <= ST_DCM_RST;
            dcm_rst <= 1'b1;
            tmr     <= '0;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            stb_cnt <= all_locked ? stb_cnt + 1'b1 : '0;
          end
        end

        ST_RELEASE, ST_RUN: begin
          // Lock loss takes precedence over a simultaneous software request.
          if (!all_locked) begin
            st       <= ST_DCM_RST;
            dcm_rst  <= 1'b1;
            rst_out  <= '1;
            seq_done <= 1'b0;
            tmr      <= '0;
            if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + 1'b1;
          end else if (sw_rst_req) begin
            st       <= ST_SW_HOLD;
            rst_out  <= '1;
            seq_done <= 1'b0;
            tmr      <= '0;
          end else if (st == ST_RELEASE && tmr == GAP_LAST) begin
            rst_out <= rst_shl;
            tmr     <= '0;
            if (rst_shl == '0) begin
              st       <= ST_RUN;
              seq_done <= 1'b1;
            end
          end
        end

        default: begin
          st       <= ST_DCM_RST;
          dcm_rst  <= 1'b1;
          rst_out  <= '1;
          seq_done <= 1'b0;
          tmr      <= '0;
        end
      endcase
    end
  end

endmodule
